uart_tx_ctrl: RTL and testbench

UART transmit frame sequencer.
- Accepts a parallel byte through a valid/ready handshake and shifts out a complete serial frame on `o_tx`: start bit, 8 data bits LSB-first, optional parity bit, then 1 or 2 stop bits.
- Each bit is held for a fixed number of clock cycles.
- Sits between the byte-producing logic and the TX pin, and owns the parity-bit generation for the frame.

---
 rtl/uart_tx_ctrl.sv | 139 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: takes a byte over valid/ready and shifts out
// start, 8 data bits LSB-first, optional parity and 1 or 2 stop bits on o_tx.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_p_data,
  input  logic       i_data_valid,
  input  logic       i_par_en,
  input  logic       i_par_typ,
  input  logic       i_stop2,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_baud_cnt;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_idx_nxt;
  logic            r_stop_cnt;
  logic [7:0]      r_data;
  logic            r_par_en;
  logic            r_par_typ;
  logic            r_stop2;
  logic            r_tx;
  logic            r_busy;
  logic            r_ready;
  logic            r_done;
  logic            w_accept;
  logic            w_bit_end;
  logic            w_stop_last;
  logic            w_par_bit;
  logic            w_tx_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;

  // Handshake: a byte transfers on a rising edge where i_data_valid and
  // o_ready are both high; valid while not ready is dropped, never queued.
  assign w_accept    = i_data_valid && r_ready;
  assign w_bit_end   = (r_baud_cnt == BAUD_LAST);
  assign w_stop_last = !r_stop2 || r_stop_cnt;
  assign w_par_bit   = r_par_typ ? ~^r_data : ^r_data;

  // State register, counters and frame configuration latch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_stop2    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      if (r_state == S_IDLE || w_bit_end) r_baud_cnt <= '0;
      else                                r_baud_cnt <= r_baud_cnt + 1'b1;
      if (r_state == S_STOP && w_bit_end) r_stop_cnt <= !w_stop_last;
      if (w_accept) begin
        r_data    <= i_p_data;
        r_par_en  <= i_par_en;
        r_par_typ <= i_par_typ;
        r_stop2   <= i_stop2;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_idx_nxt = r_bit_idx;
    unique case (r_state)
      S_IDLE: begin
        w_bit_idx_nxt = '0;
        if (w_accept) w_state_nxt = S_START;
      end
      S_START:  if (w_bit_end) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_bit_end) begin
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
      S_STOP:   if (w_bit_end && w_stop_last) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they land registered,
  // aligned with the state they describe.
  always_comb begin
    w_tx_nxt = 1'b1;
    unique case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = r_data[w_bit_idx_nxt];
      S_PARITY: w_tx_nxt = w_par_bit;
      default:  w_tx_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (r_state == S_STOP) && (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_ready <= !w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_tx    = r_tx;
  assign o_busy  = r_busy;
  assign o_ready = r_ready;
  assign o_done  = r_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed and random frames compared cycle by cycle
// against a line-level model built from the byte and frame options.
module tb_uart_tx_ctrl;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       stop2;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_err    = 0;
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_p_data    (p_data),
    .i_data_valid(data_valid),
    .i_par_en    (par_en),
    .i_par_typ   (par_typ),
    .i_stop2     (stop2),
    .o_ready     (ready),
    .o_tx        (tx),
    .o_busy      (busy),
    .o_done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, "_tx"},    32'(tx),    32'd1);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_busy"},  32'(busy),  32'd0);
    chk({tag, "_done"},  32'(done),  32'(exp_done));
  endtask

  // Line model: every serial bit becomes CPB identical samples.
  task automatic build_frame(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
    int ones;
    logic [0:0] bits[$];
    exp_q.delete();
    ones = $countones(d);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pt ? ((ones % 2) == 0) : ((ones % 2) == 1));
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[i]) for (int c = 0; c < CPB; c++) exp_q.push_back(bits[i]);
  endtask

  // Called at a negedge with the DUT ready; returns at the negedge of the done cycle.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic s2, input logic keep, input logic disturb);
    int n;
    build_frame(d, pe, pt, s2);
    n = exp_q.size();
    p_data = d; par_en = pe; par_typ = pt; stop2 = s2; data_valid = 1'b1;
    chk("ready_pre", 32'(ready), 32'd1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0 && !keep) data_valid = 1'b0;
      chk($sformatf("tx_b%0d_c%0d", k / CPB, k % CPB), 32'(tx), 32'(exp_q[k]));
      chk("busy_in_frame",  32'(busy),  32'd1);
      chk("ready_in_frame", 32'(ready), 32'd0);
      chk("done_in_frame",  32'(done),  32'd0);
      if (disturb) begin
        if (k == 5) begin
          p_data = ~d; par_typ = ~pt; par_en = ~pe; stop2 = ~s2;
        end
        if (k == 9)  data_valid = 1'b1;
        if (k == 10) data_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk_idle("frame_end", 1'b1);
  endtask

  initial begin
    rst = 1'b1; data_valid = 1'b0; p_data = '0; par_en = 0; par_typ = 0; stop2 = 0;

    repeat (3) begin
      @(negedge clk);
      chk_idle("in_reset", 1'b0);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk_idle("post_reset", 1'b0);
    end

    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk_idle("idle_after_basic", 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back: valid stays high through the done cycle.
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h3E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Inputs change and a stray valid arrives mid-frame.
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk); chk_idle("no_extra_frame", 1'b0);
    @(negedge clk); chk_idle("no_extra_frame2", 1'b0);

    for (int f = 0; f < 20; f++) begin
      int gap;
      send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); chk_idle("rand_gap", 1'b0);
      end
    end

    // Abort during data bit 3 (cycles 16..19 of the frame).
    p_data = 8'h5A; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b1; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (CPB * 4) @(negedge clk);
    chk("tx_bit3_before_rst", 32'(tx), 32'd1);
    chk("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk); chk_idle("after_abort", 1'b0);
    // Reset wins over a simultaneous valid.
    data_valid = 1'b1; p_data = 8'h00;
    @(negedge clk); chk_idle("rst_vs_valid", 1'b0);
    rst = 1'b0; data_valid = 1'b0;
    repeat (2) begin
      @(negedge clk); chk_idle("idle_after_rst", 1'b0);
    end
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk_idle("final_idle", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
